// File: rtl/wf_samp_wr_ctrl.sv
//------------------------------------------------------------------------------
// Module   : wf_samp_wr_ctrl
// Brief    : Waterfall I/Q sample-buffer write controller (single-shot/continuous,
//            sync snapshot). Optional start-up discard via WF_SAMP_SETTLE_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wf_samp_wr_ctrl #(
    parameter int IQ_WIDTH  = 16,
    parameter int ADDR_BITS = 13,
    parameter int SETTLE    = 4
) (
    input  logic                    adc_clk,
    input  logic                    reset,
    input  logic                    continuous,
    input  logic                    sync,
    input  logic                    wr_strobe,
    input  logic [IQ_WIDTH-1:0]     wr_i,
    input  logic [IQ_WIDTH-1:0]     wr_q,
    output logic                    ram_we,
    output logic [ADDR_BITS-1:0]    ram_addr,
    output logic [2*IQ_WIDTH-1:0]   ram_data,
    output logic                    full,
    output logic                    busy,
    output logic [ADDR_BITS-1:0]    sync_addr,
    output logic [7:0]              wrap_count
);

    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
`ifdef WF_SAMP_SETTLE_EN
    localparam logic [1:0] ST_SETTLE   = 2'd0;
    localparam logic [1:0] ST_START    = ST_SETTLE;
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
`else
    localparam logic [1:0] ST_START    = ST_FILL;
`endif
    localparam logic [ADDR_BITS-1:0] ADDR_LAST = {ADDR_BITS{1'b1}};

    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic                 mode;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [ADDR_BITS-1:0] wr_addr_inc;
    logic                 fill_wr;
    logic                 last_wr;
    logic                 in_settle;

`ifdef WF_SAMP_SETTLE_EN
    logic [3:0]           settle_cnt;

    assign in_settle = (state == ST_SETTLE);

    always_ff @(posedge adc_clk) begin
        if (reset) begin
            settle_cnt <= 4'd0;
        end else if (in_settle && wr_strobe) begin
            settle_cnt <= settle_cnt + 4'd1;
        end
    end
`else
    logic unused_settle;

    assign in_settle     = 1'b0;
    assign unused_settle = (SETTLE != 0);
`endif

    assign wr_addr_inc = wr_addr + ADDR_BITS'(1);

    // State register
    always_ff @(posedge adc_clk) begin
        if (reset) begin
            state <= ST_START;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
`ifdef WF_SAMP_SETTLE_EN
            ST_SETTLE: if (wr_strobe && (settle_cnt == SETTLE_LAST)) state_nxt = ST_FILL;
`endif
            ST_FILL:   if (last_wr && !mode) state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_DONE;
            default:   state_nxt = ST_START;
        endcase
    end

    // State-decoded outputs and write qualifiers
    always_comb begin
        busy    = (state != ST_DONE);
        fill_wr = (state == ST_FILL) && wr_strobe;
        last_wr = fill_wr && (wr_addr == ADDR_LAST);
    end

    // Write datapath, wrap bookkeeping and sync snapshot
    always_ff @(posedge adc_clk) begin
        if (reset) begin
            mode       <= continuous;
            wr_addr    <= '0;
            wrap_count <= 8'd0;
            sync_addr  <= '0;
            full       <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_data   <= '0;
        end else begin
            ram_we <= fill_wr;
            if (fill_wr) begin
                ram_addr <= wr_addr;
                ram_data <= {wr_i, wr_q};
                wr_addr  <= wr_addr_inc;
            end
            if (last_wr) begin
                full <= 1'b1;
                if (mode && (wrap_count != 8'hFF)) begin
                    wrap_count <= wrap_count + 8'd1;
                end
            end
            // A strobe in the same cycle as sync counts as pre-sync.
            if (sync) begin
                if (state == ST_FILL) begin
                    sync_addr <= fill_wr ? wr_addr_inc : wr_addr;
                end else if (in_settle) begin
                    sync_addr <= '0;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wf_samp_wr_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_wf_samp_wr_ctrl
// Brief    : Self-checking bench for wf_samp_wr_ctrl (vector table, directed
//            corner sequences and random traffic against a reference model).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_wf_samp_wr_ctrl;

    localparam int IQW   = 16;
    localparam int AB    = 7;
    localparam int DEPTH = 1 << AB;
    localparam int SETTLE = 4;
`ifdef WF_SAMP_SETTLE_EN
    localparam int SN = SETTLE;
`else
    localparam int SN = 0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            cont = 1'b0;
    logic            syn = 1'b0;
    logic            stb = 1'b0;
    logic [IQW-1:0]  wi = '0;
    logic [IQW-1:0]  wq = '0;
    logic            ram_we;
    logic [AB-1:0]   ram_addr;
    logic [2*IQW-1:0] ram_data;
    logic            full;
    logic            busy;
    logic [AB-1:0]   sync_addr;
    logic [7:0]      wrap_count;

    wf_samp_wr_ctrl #(
        .IQ_WIDTH (IQW),
        .ADDR_BITS(AB),
        .SETTLE   (SETTLE)
    ) dut (
        .adc_clk   (clk),
        .reset     (rst),
        .continuous(cont),
        .sync      (syn),
        .wr_strobe (stb),
        .wr_i      (wi),
        .wr_q      (wq),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .full      (full),
        .busy      (busy),
        .sync_addr (sync_addr),
        .wrap_count(wrap_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: capture described by counts of discarded and written samples
    int          m_mode  = 0;
    int          m_total = 0;
    int          m_disc  = 0;
    int          m_we    = 0;
    int          m_addr  = 0;
    logic [31:0] m_data  = '0;
    int          m_sync  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model();
        bit settling, done;
        if (rst) begin
            m_mode = int'(cont); m_total = 0; m_disc = 0;
            m_we = 0; m_addr = 0; m_data = '0; m_sync = 0;
        end else begin
            settling = (m_disc < SN);
            done     = (m_mode == 0) && (m_total >= DEPTH);
            m_we     = 0;
            if (stb && !done) begin
                if (settling) m_disc++;
                else begin
                    m_we = 1; m_addr = m_total % DEPTH; m_data = {wi, wq}; m_total++;
                end
            end
            if (syn && !done) m_sync = settling ? 0 : (m_total % DEPTH);
        end
    endtask

    task automatic step();
        int  exp_wrap;
        bit  was_rst;
        was_rst = rst;
        model();
        @(posedge clk);
        #1;
        exp_wrap = (m_mode != 0) ? ((m_total / DEPTH > 255) ? 255 : m_total / DEPTH) : 0;
        chk("ram_we", ram_we, m_we);
        if (m_we != 0) begin
            chk("ram_addr", ram_addr, m_addr);
            chk("ram_data", ram_data, m_data);
        end
        if (was_rst) begin
            chk("rst_addr", ram_addr, 0);
            chk("rst_data", ram_data, 0);
        end
        chk("full", full, (m_total >= DEPTH) ? 1 : 0);
        chk("busy", busy, ((m_mode == 0) && (m_total >= DEPTH)) ? 0 : 1);
        chk("sync_addr", sync_addr, m_sync);
        chk("wrap_count", wrap_count, exp_wrap);
    endtask

    task automatic do_reset(input logic c);
        rst = 1'b1; cont = c; stb = 1'($urandom_range(0, 1)); syn = 1'($urandom_range(0, 1));
        step();
        rst = 1'b0; stb = 1'b0; syn = 1'b0;
    endtask

    task automatic strobes(input int n);
        for (int k = 0; k < n; k++) begin
            stb = 1'b1; wi = IQW'(k); wq = ~IQW'(k);
            step();
        end
        stb = 1'b0;
    endtask

    typedef struct {
        logic           rst, cont, syn, stb;
        logic [IQW-1:0] i, q;
        logic           we;
        logic [AB-1:0]  addr;
        logic           full, busy;
        logic [AB-1:0]  sa;
        logic [7:0]     wrap;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h1111, 16'h2222, 1'b1, 7'd0, 1'b0, 1'b1, 7'd0, 8'd0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 7'd0, 1'b0, 1'b1, 7'd0, 8'd0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'hA5A5, 16'h5A5A, 1'b1, 7'd1, 1'b0, 1'b1, 7'd2, 8'd0};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 7'd0, 1'b0, 1'b1, 7'd2, 8'd0};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'hBEEF, 16'hCAFE, 1'b1, 7'd2, 1'b0, 1'b1, 7'd2, 8'd0};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0F0F, 16'hF0F0, 1'b1, 7'd3, 1'b0, 1'b1, 7'd4, 8'd0};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 7'd0, 1'b0, 1'b1, 7'd0, 8'd0};

        // Vector table: single-shot, starting at the first written sample
        do_reset(1'b0);
        strobes(SN);
        for (int k = 0; k < 7; k++) begin
            rst = tbl[k].rst; cont = tbl[k].cont; syn = tbl[k].syn; stb = tbl[k].stb;
            wi = tbl[k].i; wq = tbl[k].q;
            step();
            chk("tbl_we", ram_we, tbl[k].we);
            if (tbl[k].we) begin
                chk("tbl_addr", ram_addr, tbl[k].addr);
                chk("tbl_data", ram_data, {tbl[k].i, tbl[k].q});
            end
            chk("tbl_full", full, tbl[k].full);
            chk("tbl_busy", busy, tbl[k].busy);
            chk("tbl_sync", sync_addr, tbl[k].sa);
            chk("tbl_wrap", wrap_count, tbl[k].wrap);
        end
        rst = 1'b0; syn = 1'b0; stb = 1'b0;

        // Single-shot fill with overrun strobes
        do_reset(1'b0);
        strobes(SN + DEPTH + 4);
        chk("ss_full", full, 1);
        chk("ss_busy", busy, 0);
        chk("ss_no_we", ram_we, 0);

        // Continuous back-to-back, three wraps plus five
        do_reset(1'b1);
        strobes(SN + 3 * DEPTH + 5);
        chk("cont_wrap3", wrap_count, 3);
        chk("cont_last_addr", ram_addr, 4);
        chk("cont_full", full, 1);

        // Sync coincident with the write to address 99
        do_reset(1'b0);
        strobes(SN + 99);
        stb = 1'b1; syn = 1'b1; step(); stb = 1'b0; syn = 1'b0;
        chk("sync99_addr", ram_addr, 99);
        chk("sync99_sa", sync_addr, 100);

        // Sync on the final address in continuous mode wraps to 0
        do_reset(1'b1);
        strobes(SN + DEPTH - 1);
        stb = 1'b1; syn = 1'b1; step(); stb = 1'b0; syn = 1'b0;
        chk("synclast_addr", ram_addr, DEPTH - 1);
        chk("synclast_sa", sync_addr, 0);

        // Reset mid-fill (after one wrap) with a coincident strobe
        do_reset(1'b1);
        strobes(SN + DEPTH + 50);
        rst = 1'b1; cont = 1'b1; stb = 1'b1; syn = 1'b0; wi = 16'h1234; wq = 16'h5678;
        step();
        rst = 1'b0; stb = 1'b0;
        chk("abort_we", ram_we, 0);
        chk("abort_wrap", wrap_count, 0);
        chk("abort_full", full, 0);
        strobes(SN + 1);
        chk("abort_restart", ram_addr, 0);

        // continuous toggling outside reset is ignored
        do_reset(1'b0);
        for (int k = 0; k < SN + DEPTH + 3; k++) begin
            cont = 1'($urandom_range(0, 1)); stb = 1'b1; wi = IQW'($urandom); wq = IQW'($urandom);
            step();
        end
        stb = 1'b0;
        chk("tog_busy", busy, 0);
        chk("tog_full", full, 1);
        chk("tog_wrap", wrap_count, 0);

        // Wrap-count saturation
        do_reset(1'b1);
        strobes(SN + 300 * DEPTH);
        chk("wrap_sat", wrap_count, 255);

        // Random traffic
        for (int k = 0; k < 6000; k++) begin
            rst  = ($urandom_range(0, 299) == 0);
            cont = 1'($urandom_range(0, 1));
            syn  = ($urandom_range(0, 7) == 0);
            stb  = ($urandom_range(0, 3) != 0);
            wi   = IQW'($urandom);
            wq   = IQW'($urandom);
            step();
        end
        rst = 1'b0; stb = 1'b0; syn = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
